// File: rtl/demux1to3_buf.sv
// Buffered 1-to-3 valid/ready demultiplexer.
// Each destination owns a 2-entry FIFO, so one stalled consumer does not block the other destinations.
module demux1to3_buf #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_data,
    input  logic [1:0]      s,
    output logic            out1_valid,
    output logic            out2_valid,
    output logic            out3_valid,
    input  logic            out1_ready,
    input  logic            out2_ready,
    input  logic            out3_ready,
    output logic [size-1:0] out1_data,
    output logic [size-1:0] out2_data,
    output logic [size-1:0] out3_data,
    output logic [7:0]      drop_cnt
);

    logic [size-1:0] r_mem [3][2];
    logic [2:0]      r_wr_ptr;
    logic [2:0]      r_rd_ptr;
    logic [1:0]      r_cnt [3];
    logic [7:0]      r_drop_cnt;

    logic [2:0] w_full;
    logic [2:0] w_valid;
    logic [2:0] w_oready;
    logic [2:0] w_push;
    logic [2:0] w_pop;
    logic       w_accept;
    logic       w_drop;

    always_comb begin
        w_oready = {out3_ready, out2_ready, out1_ready};
        for (int unsigned k = 0; k < 3; k++) begin
            w_full[k]  = (r_cnt[k] == 2'd2);
            w_valid[k] = (r_cnt[k] != 2'd0);
        end
        // Ready never looks at the consumer side: a full FIFO refuses even when being popped.
        case (s)
            2'b00:   in_ready = !w_full[0];
            2'b01:   in_ready = !w_full[1];
            2'b10:   in_ready = !w_full[2];
            default: in_ready = 1'b1;
        endcase
        w_accept = in_valid & in_ready;
        w_drop   = w_accept & (s == 2'b11);
        w_push   = {w_accept & (s == 2'b10),
                    w_accept & (s == 2'b01),
                    w_accept & (s == 2'b00)};
        w_pop    = w_valid & w_oready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 3; k++) begin
                r_mem[k][0] <= '0;
                r_mem[k][1] <= '0;
                r_cnt[k]    <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (w_push[k]) begin
                    r_mem[k][r_wr_ptr[k]] <= in_data;
                    r_wr_ptr[k]           <= ~r_wr_ptr[k];
                end
                if (w_pop[k]) begin
                    r_rd_ptr[k] <= ~r_rd_ptr[k];
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + 2'd1;
                    2'b01:   r_cnt[k] <= r_cnt[k] - 2'd1;
                    default: r_cnt[k] <= r_cnt[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign out1_valid = w_valid[0];
    assign out2_valid = w_valid[1];
    assign out3_valid = w_valid[2];
    assign out1_data  = r_mem[0][r_rd_ptr[0]];
    assign out2_data  = r_mem[1][r_rd_ptr[1]];
    assign out3_data  = r_mem[2][r_rd_ptr[2]];
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_demux1to3_buf.sv
// Scoreboarded bench for demux1to3_buf: stimulus enqueues expected words per destination,
// a negedge monitor checks every pop against the queue head.
module tb_demux1to3_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  s;
    logic        out1_valid, out2_valid, out3_valid;
    logic        out1_ready, out2_ready, out3_ready;
    logic [31:0] out1_data, out2_data, out3_data;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q [3][$];

    demux1to3_buf #(.size(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .s(s),
        .out1_valid(out1_valid), .out2_valid(out2_valid), .out3_valid(out3_valid),
        .out1_ready(out1_ready), .out2_ready(out2_ready), .out3_ready(out3_ready),
        .out1_data(out1_data), .out2_data(out2_data), .out3_data(out3_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic r, input logic [31:0] d);
        if (v && r) begin
            n_cmp++;
            if (q[k].size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected dest%0d: got 0x%08h, expected no word", k + 1, d);
            end else begin
                if (d !== q[k][0]) begin
                    n_err++;
                    $display("FAIL pop_order dest%0d: got 0x%08h, expected 0x%08h", k + 1, d, q[k][0]);
                end
                void'(q[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, out1_valid, out1_ready, out1_data);
            mon(1, out2_valid, out2_ready, out2_data);
            mon(2, out3_valid, out3_ready, out3_data);
        end
    end

    function automatic logic dest_valid(input logic [1:0] sel);
        case (sel)
            2'b00:   return out1_valid;
            2'b01:   return out2_valid;
            default: return out3_valid;
        endcase
    endfunction

    function automatic logic [31:0] dest_data(input logic [1:0] sel);
        case (sel)
            2'b00:   return out1_data;
            2'b01:   return out2_data;
            default: return out3_data;
        endcase
    endfunction

    // Leaves in_valid high; the caller follows with another push or idle() without advancing time.
    task automatic push(input logic [1:0] sel, input logic [31:0] d, output int waits);
        logic was_empty;
        in_valid = 1'b1;
        s        = sel;
        in_data  = d;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: in_ready 0 for 20 cycles, expected 1 (word 0x%08h)", d);
            in_valid = 1'b0;
            return;
        end
        was_empty = (sel != 2'b11) && (q[sel].size() == 0);
        if (sel != 2'b11) q[sel].push_back(d);
        @(posedge clk);
        #1;
        if (was_empty) begin
            check("latency_valid", {31'b0, dest_valid(sel)}, 32'd1);
            check("latency_data", dest_data(sel), d);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain();
        int cyc = 0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        out3_ready = 1'b1;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0",
                     q[0].size() + q[1].size() + q[2].size());
        end
        @(posedge clk);
        #1;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        out3_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", {29'b0, out3_valid, out2_valid, out1_valid}, 32'd0);
    endtask

    initial begin
        int w;
        rst        = 1'b1;
        in_valid   = 1'b1;
        s          = 2'b00;
        in_data    = 32'hDEADBEEF;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        out3_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Reset / idle
        @(negedge clk);
        check("rst_valid", {29'b0, out3_valid, out2_valid, out1_valid}, 32'd0);
        check("rst_data1", out1_data, 32'd0);
        check("rst_data2", out2_data, 32'd0);
        check("rst_data3", out3_data, 32'd0);
        check("rst_drop", {24'b0, drop_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #1;
            check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        end

        // Steering, consumers stalled
        @(posedge clk);
        #1;
        push(2'b00, 32'h11, w);
        push(2'b01, 32'h22, w);
        push(2'b10, 32'h33, w);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("steer_valid", {29'b0, out3_valid, out2_valid, out1_valid}, 32'd7);
        check("steer_d1", out1_data, 32'h11);
        check("steer_d2", out2_data, 32'h22);
        check("steer_d3", out3_data, 32'h33);
        drain();

        // Backpressure / full on destination 2
        @(posedge clk);
        #1;
        push(2'b01, 32'hA1, w);
        push(2'b01, 32'hA2, w);
        in_valid = 1'b1;
        s        = 2'b01;
        in_data  = 32'hA3;
        @(negedge clk);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_head", out2_data, 32'hA1);
        @(posedge clk);
        #1;
        out2_ready = 1'b1;
        push(2'b01, 32'hA3, w);
        check("full_ready_return", w, 32'd1);
        idle();
        drain();

        // Isolation: destination 1 full and stalled
        @(posedge clk);
        #1;
        push(2'b00, 32'hB1, w);
        push(2'b00, 32'hB2, w);
        push(2'b10, 32'h55, w);
        check("iso_no_wait", w, 32'd0);
        idle();
        @(negedge clk);
        check("iso_d3", out3_data, 32'h55);
        check("iso_v1", {31'b0, out1_valid}, 32'd1);
        check("iso_d1", out1_data, 32'hB1);
        drain();

        // Simultaneous push and pop at count 1, then streaming
        @(posedge clk);
        #1;
        push(2'b10, 32'h01, w);
        out3_ready = 1'b1;
        push(2'b10, 32'h02, w);
        check("simul_valid", {31'b0, out3_valid}, 32'd1);
        check("simul_data", out3_data, 32'h02);
        for (int i = 1; i <= 10; i++) begin
            push(2'b10, 32'(i), w);
            check("stream_no_wait", w, 32'd0);
        end
        idle();
        drain();

        // Drop path and saturation
        @(posedge clk);
        #1;
        for (int i = 1; i <= 260; i++) begin
            push(2'b11, 32'hC000_0000 + 32'(i), w);
            check("drop_no_wait", w, 32'd0);
            check("drop_no_valid", {29'b0, out3_valid, out2_valid, out1_valid}, 32'd0);
            if (i == 10)  check("drop_cnt_10", {24'b0, drop_cnt}, 32'd10);
            if (i == 255) check("drop_cnt_255", {24'b0, drop_cnt}, 32'd255);
        end
        idle();
        @(negedge clk);
        check("drop_cnt_sat", {24'b0, drop_cnt}, 32'd255);
        check("final_queues", q[0].size() + q[1].size() + q[2].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
